instruction_fetch: RTL

- Fetch stage directly upstream of the instruction field decoder.
- Holds the program counter, an internal word-organised instruction memory with a program-load write port, and the IF/ID output register.
- Delivers one 32-bit instruction per cycle with its PC and a valid flag.
- Honours stall and branch-redirect requests from later stages, and flags misaligned or out-of-range fetches.

---
 rtl/instruction_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, word-organised instruction memory, IF/ID register.
// Ports: clk, reset, stall, branch_*, prog_*, instruction_out, pc_out, valid_out, fetch_fault.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        prog_we,
  input  logic [63:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic [31:0] instruction_out,
  output logic [63:0] pc_out,
  output logic        valid_out,
  output logic        fetch_fault
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [31:0] instr_n;
  logic [63:0] pc_out_n;
  logic        valid_n;
  logic        fault_n;

  logic [31:0] mem [MEM_WORDS];
  logic [63:0] pc_word;
  logic [31:0] rd_word;
  logic [AW-1:0] waddr;
  logic        unused_addr;

  assign pc_word = pc >> 2;
  assign rd_word = mem[pc[AW+1:2]];
  assign waddr   = prog_addr[AW+1:2];
  assign unused_addr = ^{prog_addr[63:AW+2], prog_addr[1:0]};

  // Write port is independent of the fetch FSM; the read above is
  // combinational from the old contents, so same-edge reads see old data.
  always_ff @(posedge clk) begin
    if (prog_we) mem[waddr] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      instruction_out <= NOP;
      pc_out          <= 64'h0;
      valid_out       <= 1'b0;
      fetch_fault     <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      instruction_out <= instr_n;
      pc_out          <= pc_out_n;
      valid_out       <= valid_n;
      fetch_fault     <= fault_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instruction_out;
    pc_out_n = pc_out;
    valid_n  = valid_out;
    fault_n  = fetch_fault;
    unique case (state)
      IDLE: begin
        if (!prog_we) state_n = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          instr_n = NOP;
          if (branch_target[1:0] != 2'b00) begin
            state_n = FAULT;
            fault_n = 1'b1;
          end else begin
            pc_n = branch_target;
          end
        end else if (stall) begin
          state_n = FETCH;
        end else if (pc_word >= 64'(MEM_WORDS)) begin
          state_n = FAULT;
          fault_n = 1'b1;
          valid_n = 1'b0;
          instr_n = NOP;
        end else begin
          instr_n  = rd_word;
          pc_out_n = pc;
          valid_n  = 1'b1;
          pc_n     = pc + 64'd4;
        end
      end
      FAULT: begin
        valid_n = 1'b0;
        instr_n = NOP;
        fault_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
